sap_cpu_core: RTL

Parametrised successor to the team's 8-bit bus-based teaching CPU. It is a single-clock, microcoded accumulator machine with an internal flop-array program/data RAM, a wider ISA (conditional jumps, immediate load, store), an explicit halt, and a host programming port. It sits directly under the TinyTapeout top wrapper, which maps `ui_in`/`uio` onto the programming and run controls and `uo_out` onto `out_data`.

---
 rtl/sap_cpu_pkg.sv | 26 ++
 rtl/sap_cpu_core_ram.sv | 20 ++
 rtl/sap_cpu_core.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sap_cpu_pkg.sv
// sap_cpu_pkg: opcodes, FSM states and instruction-field helpers shared by the SAP CPU.
package sap_cpu_pkg;
   localparam int OP_W = 4;
   localparam logic [OP_W-1:0] OP_NOP = 4'h0;
   localparam logic [OP_W-1:0] OP_LDA = 4'h1;
   localparam logic [OP_W-1:0] OP_ADD = 4'h2;
   localparam logic [OP_W-1:0] OP_SUB = 4'h3;
   localparam logic [OP_W-1:0] OP_STA = 4'h4;
   localparam logic [OP_W-1:0] OP_LDI = 4'h5;
   localparam logic [OP_W-1:0] OP_JMP = 4'h6;
   localparam logic [OP_W-1:0] OP_JC  = 4'h7;
   localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
   localparam logic [OP_W-1:0] OP_OUT = 4'hE;
   localparam logic [OP_W-1:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_EX1, S_EX2, S_EX3, S_HALT} state_t;

   // Opcodes that need a second memory access through MAR.
   function automatic logic uses_mem(input logic [OP_W-1:0] op);
      return op == OP_LDA || op == OP_ADD || op == OP_SUB || op == OP_STA;
   endfunction

   function automatic logic is_alu(input logic [OP_W-1:0] op);
      return op == OP_ADD || op == OP_SUB;
   endfunction
endpackage

// File: rtl/sap_cpu_core_ram.sv
// sap_ram: flop-array RAM with one synchronous write port and one combinational read port.
module sap_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sap_cpu_core.sv
// sap_cpu_core: microcoded accumulator CPU with internal RAM and a host programming port.
module sap_cpu_core import sap_cpu_pkg::*; #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_wdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic              busy,
   output logic [ADDR_W-1:0] pc,
   output logic              cf,
   output logic              zf
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d, opnd, ram_waddr;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d, out_q, out_d, ram_rdata, ram_wdata;
   logic              cf_q, cf_d, zf_q, zf_d, out_valid_q, out_valid_d, ram_we, idle, sub;
   logic [OP_W-1:0]   op;
   logic [DATA_W:0]   sum;

   assign op   = ir_q[DATA_W-1 -: OP_W];
   assign opnd = ir_q[ADDR_W-1:0];
   assign idle = state_q == S_IDLE || state_q == S_HALT;

   sap_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .raddr(mar_q),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_HALT: state_d = run ? S_F0 : state_q;
         S_F0:           state_d = S_F1;
         S_F1:           state_d = S_EX1;
         S_EX1:          state_d = uses_mem(op) ? S_EX2 : (op == OP_HLT ? S_HALT : S_F0);
         S_EX2:          state_d = is_alu(op) ? S_EX3 : S_F0;
         default:        state_d = S_F0;
      endcase
   end

   // Write port is shared: host owns it while stopped, STA owns it in EX2; reset blocks both.
   always_comb begin
      halted    = state_q == S_HALT;
      busy      = !idle;
      ram_we    = !rst && (idle ? prog_we : (state_q == S_EX2 && op == OP_STA));
      ram_waddr = idle ? prog_addr : mar_q;
      ram_wdata = idle ? prog_wdata : a_q;
   end

   always_comb begin
      pc_d        = pc_q;
      mar_d       = mar_q;
      a_d         = a_q;
      b_d         = b_q;
      ir_d        = ir_q;
      cf_d        = cf_q;
      zf_d        = zf_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      sub         = op == OP_SUB;
      sum         = {1'b0, a_q} + {1'b0, sub ? ~b_q : b_q} + {{DATA_W{1'b0}}, sub};
      case (state_q)
         S_IDLE, S_HALT: begin
            pc_d = run ? '0 : pc_q;
            a_d  = run ? '0 : a_q;
            b_d  = run ? '0 : b_q;
            cf_d = run ? 1'b0 : cf_q;
            zf_d = run ? 1'b0 : zf_q;
         end
         S_F0: mar_d = pc_q;
         S_F1: begin
            ir_d = ram_rdata;
            pc_d = pc_q + ADDR_W'(1);
         end
         S_EX1: begin
            mar_d       = uses_mem(op) ? opnd : mar_q;
            a_d         = op == OP_LDI ? {{(DATA_W-ADDR_W){1'b0}}, opnd} : a_q;
            pc_d        = (op == OP_JMP || (op == OP_JC && cf_q) || (op == OP_JZ && zf_q)) ? opnd : pc_q;
            out_d       = op == OP_OUT ? a_q : out_q;
            out_valid_d = op == OP_OUT;
         end
         S_EX2: begin
            a_d = op == OP_LDA ? ram_rdata : a_q;
            b_d = is_alu(op) ? ram_rdata : b_q;
         end
         S_EX3: begin
            a_d  = sum[DATA_W-1:0];
            cf_d = sum[DATA_W];
            zf_d = sum[DATA_W-1:0] == '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= '0;
         mar_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ir_q        <= '0;
         cf_q        <= 1'b0;
         zf_q        <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         mar_q       <= mar_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ir_q        <= ir_d;
         cf_q        <= cf_d;
         zf_q        <= zf_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_q;
   assign out_valid = out_valid_q;
   assign pc        = pc_q;
   assign cf        = cf_q;
   assign zf        = zf_q;
endmodule
